// File: rtl/cache_line_refill_pkg.sv
// Shared defaults for the cache line-refill stage.
// Geometry matches the cache's default configuration.
package cache_line_refill_pkg;

    localparam int CLR_N_WAYS     = 8;
    localparam int CLR_LINE_OFF_W = 7;
    localparam int CLR_WORD_OFF_W = 3;
    localparam int CLR_TAG_W      = 20;
    localparam int CLR_DATA_W     = 32;

    // Width of a back-end word address {tag, index, word}.
    function automatic int be_addr_w(input int tag_w, input int line_w,
                                     input int word_w);
        return tag_w + line_w + word_w;
    endfunction

endpackage

// File: rtl/cache_line_refill.sv
// Read-miss refill: fetch a whole line word by word into the
// victim way, then commit tag/valid and update the policy.
module cache_line_refill
    import cache_line_refill_pkg::*;
#(
    parameter int N_WAYS     = CLR_N_WAYS,
    parameter int NWAY_W     = $clog2(N_WAYS),
    parameter int LINE_OFF_W = CLR_LINE_OFF_W,
    parameter int WORD_OFF_W = CLR_WORD_OFF_W,
    parameter int TAG_W      = CLR_TAG_W,
    parameter int DATA_W     = CLR_DATA_W,
    parameter int BE_ADDR_W  = be_addr_w(TAG_W, LINE_OFF_W, WORD_OFF_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss,
    input  logic [TAG_W-1:0]      miss_tag,
    input  logic [LINE_OFF_W-1:0] miss_index,
    input  logic [NWAY_W-1:0]     way_select_bin,
    output logic                  busy,
    output logic                  be_valid,
    output logic [BE_ADDR_W-1:0]  be_addr,
    input  logic                  be_ready,
    input  logic [DATA_W-1:0]     be_rdata,
    output logic [N_WAYS-1:0]     fill_we,
    output logic [LINE_OFF_W-1:0] fill_index,
    output logic [WORD_OFF_W-1:0] fill_word,
    output logic [DATA_W-1:0]     fill_wdata,
    output logic [N_WAYS-1:0]     tag_we,
    output logic [TAG_W-1:0]      tag_wdata,
    output logic                  policy_we,
    output logic [N_WAYS-1:0]     policy_way_hit,
    output logic [LINE_OFF_W-1:0] policy_line_addr,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        COMMIT = ST_COMMIT
    } state_e;

    state_e                  state_q,    state_d;
    logic [WORD_OFF_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TAG_W-1:0]        tag_q,      tag_d;
    logic [LINE_OFF_W-1:0]   index_q,    index_d;
    logic [NWAY_W-1:0]       way_q,      way_d;
    logic [N_WAYS-1:0]       way_oh;

    assign way_oh           = N_WAYS'(1) << way_q;
    assign fill_index       = index_q;
    assign policy_line_addr = index_q;
    assign fill_word        = word_cnt_q;
    assign be_addr          = {tag_q, index_q, word_cnt_q};
    assign busy             = (state_q != IDLE);

    // State, word counter and miss latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            way_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            way_q      <= way_d;
        end
    end

    // Next state and per-cycle memory/back-end/policy strobes.
    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        tag_d          = tag_q;
        index_d        = index_q;
        way_d          = way_q;
        be_valid       = 1'b0;
        fill_we        = '0;
        fill_wdata     = '0;
        tag_we         = '0;
        tag_wdata      = '0;
        policy_we      = 1'b0;
        policy_way_hit = '0;
        done           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    tag_d      = miss_tag;
                    index_d    = miss_index;
                    way_d      = way_select_bin;
                    word_cnt_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                be_valid = 1'b1;
                if (be_ready) begin
                    fill_we    = way_oh;
                    fill_wdata = be_rdata;
                    word_cnt_d = word_cnt_q + WORD_OFF_W'(1);
                    if (&word_cnt_q) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                tag_we         = way_oh;
                tag_wdata      = tag_q;
                policy_we      = 1'b1;
                policy_way_hit = way_oh;
                done           = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill.
// Default geometry: 8 ways, 8 words per line.
module tb_cache_line_refill;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss;
    logic [19:0] miss_tag;
    logic [6:0]  miss_index;
    logic [2:0]  way_select_bin;
    logic        busy;
    logic        be_valid;
    logic [29:0] be_addr;
    logic        be_ready;
    logic [31:0] be_rdata;
    logic [7:0]  fill_we;
    logic [6:0]  fill_index;
    logic [2:0]  fill_word;
    logic [31:0] fill_wdata;
    logic [7:0]  tag_we;
    logic [19:0] tag_wdata;
    logic        policy_we;
    logic [7:0]  policy_way_hit;
    logic [6:0]  policy_line_addr;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_line_refill dut (
        .clk(clk), .reset(reset), .miss(miss),
        .miss_tag(miss_tag), .miss_index(miss_index),
        .way_select_bin(way_select_bin), .busy(busy),
        .be_valid(be_valid), .be_addr(be_addr),
        .be_ready(be_ready), .be_rdata(be_rdata),
        .fill_we(fill_we), .fill_index(fill_index),
        .fill_word(fill_word), .fill_wdata(fill_wdata),
        .tag_we(tag_we), .tag_wdata(tag_wdata),
        .policy_we(policy_we), .policy_way_hit(policy_way_hit),
        .policy_line_addr(policy_line_addr), .done(done)
    );

    // One full refill. Inputs change on the falling edge, checks 1ns later.
    // rdy_pat supplies be_ready per FETCH cycle (LSB first, then 1s).
    task automatic run_refill(input logic [19:0] tag, input logic [6:0] idx,
                              input logic [2:0] way, input logic [2:0] way_chg,
                              input logic [15:0] rdy_pat, input int exp_fetch,
                              input bit hold, input string nm);
        logic [7:0]  oh;
        logic [31:0] d;
        logic [2:0]  wb;
        int w;
        int cyc;
        oh = 8'h01 << way;
        @(negedge clk);
        miss = 1'b1; miss_tag = tag; miss_index = idx;
        way_select_bin = way; be_ready = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || be_valid !== 1'b0 || fill_we !== 8'h00) begin
            n_err++;
            $display("FAIL %s idle: busy=%b be_valid=%b fill_we=%h want 0/0/00",
                     nm, busy, be_valid, fill_we);
        end
        w = 0;
        cyc = 0;
        @(negedge clk);
        if (!hold) miss = 1'b0;
        while (w < 8 && cyc < 64) begin
            wb = w[2:0];
            be_ready = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
            d = {8'hD0, tag[15:0], 5'd0, wb};
            be_rdata = d;
            if (cyc == 2) way_select_bin = way_chg;
            #1;
            n_cmp++;
            if (be_valid !== 1'b1 || be_addr !== {tag, idx, wb}) begin
                n_err++;
                $display("FAIL %s be word%0d: valid=%b addr=%h want 1/%h",
                         nm, w, be_valid, be_addr, {tag, idx, wb});
            end
            n_cmp++;
            if (fill_we !== (be_ready ? oh : 8'h00)) begin
                n_err++;
                $display("FAIL %s fill_we cyc%0d: got %h want %h",
                         nm, cyc, fill_we, be_ready ? oh : 8'h00);
            end
            if (be_ready) begin
                n_cmp++;
                if (fill_wdata !== d || fill_word !== wb || fill_index !== idx) begin
                    n_err++;
                    $display("FAIL %s fill data w%0d: got %h/%0d/%h want %h/%0d/%h",
                             nm, w, fill_wdata, fill_word, fill_index, d, wb, idx);
                end
            end
            n_cmp++;
            if (done !== 1'b0 || tag_we !== 8'h00 || policy_we !== 1'b0) begin
                n_err++;
                $display("FAIL %s early commit cyc%0d: done=%b tag_we=%h pwe=%b",
                         nm, cyc, done, tag_we, policy_we);
            end
            if (be_ready) w++;
            cyc++;
            @(negedge clk);
        end
        be_ready = 1'b1;
        #1;
        n_cmp++;
        if (cyc !== exp_fetch) begin
            n_err++;
            $display("FAIL %s fetch cycles: got %0d want %0d", nm, cyc, exp_fetch);
        end
        n_cmp++;
        if (done !== 1'b1 || tag_we !== oh || tag_wdata !== tag) begin
            n_err++;
            $display("FAIL %s commit tag: done=%b tag_we=%h tag=%h want 1/%h/%h",
                     nm, done, tag_we, tag_wdata, oh, tag);
        end
        n_cmp++;
        if (policy_we !== 1'b1 || policy_way_hit !== oh ||
            policy_line_addr !== idx) begin
            n_err++;
            $display("FAIL %s commit policy: we=%b hit=%h line=%h want 1/%h/%h",
                     nm, policy_we, policy_way_hit, policy_line_addr, oh, idx);
        end
        n_cmp++;
        if (fill_we !== 8'h00 || be_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s commit misc: fill_we=%h be_valid=%b busy=%b",
                     nm, fill_we, be_valid, busy);
        end
        if (!hold) be_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; miss = 1'b0; miss_tag = '0; miss_index = '0;
        way_select_bin = '0; be_ready = 1'b0; be_rdata = '0;
        #12;
        n_cmp++;
        if (busy !== 1'b0 || be_valid !== 1'b0 || be_addr !== 30'h0 ||
            fill_we !== 8'h00 || tag_we !== 8'h00 || policy_we !== 1'b0 ||
            policy_way_hit !== 8'h00 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b bv=%b addr=%h fwe=%h twe=%h pwe=%b hit=%h done=%b want all 0",
                     busy, be_valid, be_addr, fill_we, tag_we, policy_we,
                     policy_way_hit, done);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        run_refill(20'h12345, 7'h05, 3'd3, 3'd3, 16'hFFFF, 8, 1'b0, "basic");
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || tag_we !== 8'h00) begin
            n_err++;
            $display("FAIL basic after: busy=%b done=%b tag_we=%h want 0/0/00",
                     busy, done, tag_we);
        end
    endtask

    task automatic test_stall();
        run_refill(20'hABCDE, 7'h7F, 3'd0, 3'd0, 16'hFFF9, 10, 1'b0, "stall");
    endtask

    task automatic test_way_change();
        run_refill(20'h0F0F0, 7'h2A, 3'd3, 3'd6, 16'hFFFF, 8, 1'b0, "waychg");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        miss = 1'b1; miss_tag = 20'h55555; miss_index = 7'h11;
        way_select_bin = 3'd5; be_ready = 1'b1;
        @(negedge clk);
        miss = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (be_valid !== 1'b0 || busy !== 1'b0 || fill_we !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid drop: be_valid=%b busy=%b fill_we=%h want 0/0/00",
                     be_valid, busy, fill_we);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (tag_we !== 8'h00 || done !== 1'b0 || policy_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid commit: tag_we=%h done=%b pwe=%b want 00/0/0",
                     tag_we, done, policy_we);
        end
        reset = 1'b1;
        be_ready = 1'b0;
        run_refill(20'h00777, 7'h11, 3'd5, 3'd5, 16'hFFFF, 8, 1'b0, "rst_redo");
    endtask

    task automatic test_back_to_back();
        run_refill(20'h11111, 7'h01, 3'd1, 3'd1, 16'hFFFF, 8, 1'b1, "b2b_1");
        run_refill(20'h22222, 7'h02, 3'd7, 3'd7, 16'hFFFF, 8, 1'b0, "b2b_2");
    endtask

    task automatic test_idle_ready();
        @(negedge clk);
        miss = 1'b0; be_ready = 1'b1; be_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (fill_we !== 8'h00 || busy !== 1'b0 || be_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ready %0d: fill_we=%h busy=%b bv=%b want 00/0/0",
                         i, fill_we, busy, be_valid);
            end
            @(negedge clk);
        end
        be_ready = 1'b0;
        run_refill(20'h3C3C3, 7'h40, 3'd2, 3'd2, 16'hFFFF, 8, 1'b0, "idle_redo");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_way_change();
        test_reset_mid();
        test_back_to_back();
        test_idle_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
